// File: rtl/ssi_check_pkg.sv
// Shared types and PRBS helpers for the SSI loopback pattern checker.
package ssi_check_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'd0,
        MODE_PRBS7  = 2'd1,
        MODE_PRBS15 = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        SEARCH = 2'd2,
        LOCKED = 2'd3
    } state_e;

    localparam int PN_MAX_WIDTH = 32;

    // Word holds `width` consecutive sequence bits, oldest in the MSB; shift in `width` new bits.
    function automatic logic [31:0] pn_advance(input logic [31:0] word, input int width,
                                               input int tap_a, input int tap_b);
        logic [31:0] w;
        logic [31:0] mask;
        w = word;
        for (int i = 0; i < PN_MAX_WIDTH; i++) begin
            w = (i < width) ? {w[30:0], w[tap_a[4:0]] ^ w[tap_b[4:0]]} : w;
        end
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return w & mask;
    endfunction

    // x^7 + x^6 + 1
    function automatic logic [31:0] pn7_next(input logic [31:0] word, input int width);
        return pn_advance(word, width, 6, 5);
    endfunction

    // x^15 + x^14 + 1
    function automatic logic [31:0] pn15_next(input logic [31:0] word, input int width);
        return pn_advance(word, width, 14, 13);
    endfunction

endpackage

// File: rtl/ssi_check_channel.sv
// One I/Q lane pair: self-seeding pattern predictor, lock/loss-of-lock FSM and error counters.
module ssi_check_channel
    import ssi_check_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int LOCK_COUNT    = 8,
    parameter int LOSS_COUNT    = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic                     clear,
    input  logic                     data_valid,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic [DATA_WIDTH-1:0]    data_q,
    output logic                     locked,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     lock_lost
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(LOSS_COUNT + 1);

    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [DATA_WIDTH-1:0]    prev_i_q, prev_i_d, prev_q_q, prev_q_d;
    logic [GOOD_W-1:0]        good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]         bad_cnt_q, bad_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, err_upd_s, err_inc_s;
    logic                     sticky_q, sticky_d, sticky_upd_s;
    logic                     locked_q, locked_d;
    logic                     lost_q, lost_d;
    logic [DATA_WIDTH-1:0]    exp_i_s, exp_q_s;
    logic                     active_s, match_s;

    function automatic logic [DATA_WIDTH-1:0] predict(input logic [DATA_WIDTH-1:0] prev,
                                                      input mode_e md);
        logic [DATA_WIDTH-1:0] nxt;
        case (md)
            MODE_RAMP:   nxt = prev + DATA_WIDTH'(1);
            MODE_PRBS7:  nxt = DATA_WIDTH'(pn7_next(32'(prev), DATA_WIDTH));
            MODE_PRBS15: nxt = DATA_WIDTH'(pn15_next(32'(prev), DATA_WIDTH));
            default:     nxt = prev;
        endcase
        return nxt;
    endfunction

    // Next-state, predictor and counter update for one channel.
    always_comb begin
        mode_d       = mode_e'(mode);
        active_s     = enable && (mode_d != MODE_OFF);
        exp_i_s      = predict(prev_i_q, mode_d);
        exp_q_s      = predict(prev_q_q, mode_d);
        match_s      = (data_i == exp_i_s) && (data_q == exp_q_s);
        err_inc_s    = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_WIDTH'(1);

        state_d      = state_q;
        prev_i_d     = prev_i_q;
        prev_q_d     = prev_q_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        err_upd_s    = err_cnt_q;
        sticky_upd_s = sticky_q;
        lost_d       = 1'b0;

        if (!active_s || (mode_d != mode_q)) begin
            state_d    = IDLE;
            prev_i_d   = '0;
            prev_q_d   = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = SEED;
                SEED: begin
                    if (data_valid) begin
                        prev_i_d   = data_i;
                        prev_q_d   = data_q;
                        good_cnt_d = '0;
                        state_d    = SEARCH;
                    end else begin
                        state_d = SEED;
                    end
                end
                SEARCH: begin
                    if (data_valid) begin
                        prev_i_d = data_i;
                        prev_q_d = data_q;
                        if (!match_s) begin
                            good_cnt_d = '0;
                        end else if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                            state_d    = LOCKED;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!data_valid) begin
                        state_d = LOCKED;
                    end else if (match_s) begin
                        prev_i_d  = data_i;
                        prev_q_d  = data_q;
                        bad_cnt_d = '0;
                    end else begin
                        // Flywheel on the prediction so one corrupted word costs one error, not two.
                        prev_i_d     = exp_i_s;
                        prev_q_d     = exp_q_s;
                        err_upd_s    = err_inc_s;
                        sticky_upd_s = 1'b1;
                        if (bad_cnt_q == BAD_W'(LOSS_COUNT - 1)) begin
                            bad_cnt_d  = '0;
                            good_cnt_d = '0;
                            lost_d     = 1'b1;
                            state_d    = SEARCH;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BAD_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_cnt_d = clear ? '0 : err_upd_s;
        sticky_d  = clear ? 1'b0 : sticky_upd_s;
        locked_d  = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_RAMP;
            prev_i_q   <= '0;
            prev_q_q   <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_cnt_q  <= '0;
            sticky_q   <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            prev_i_q   <= prev_i_d;
            prev_q_q   <= prev_q_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            err_cnt_q  <= err_cnt_d;
            sticky_q   <= sticky_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
        end
    end

    assign locked     = locked_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_cnt_q;
    assign lock_lost  = lost_q;

endmodule

// File: rtl/ssi_loopback_checker.sv
// Multi-channel SSI loopback pattern checker: one independent checker per RX channel.
module ssi_loopback_checker
    import ssi_check_pkg::*;
#(
    parameter int NUM_CHANNELS  = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int LOCK_COUNT    = 8,
    parameter int LOSS_COUNT    = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [1:0]                            mode,
    input  logic                                  clear,
    input  logic [NUM_CHANNELS-1:0]               data_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    data_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    data_q,
    output logic [NUM_CHANNELS-1:0]               locked,
    output logic [NUM_CHANNELS-1:0]               err_sticky,
    output logic [NUM_CHANNELS*ERR_CNT_WIDTH-1:0] err_count,
    output logic [NUM_CHANNELS-1:0]               lock_lost
);

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        ssi_check_channel #(
            .DATA_WIDTH   (DATA_WIDTH),
            .LOCK_COUNT   (LOCK_COUNT),
            .LOSS_COUNT   (LOSS_COUNT),
            .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .mode      (mode),
            .clear     (clear),
            .data_valid(data_valid[k]),
            .data_i    (data_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .data_q    (data_q[k*DATA_WIDTH +: DATA_WIDTH]),
            .locked    (locked[k]),
            .err_sticky(err_sticky[k]),
            .err_count (err_count[k*ERR_CNT_WIDTH +: ERR_CNT_WIDTH]),
            .lock_lost (lock_lost[k])
        );
    end

endmodule
